fetch_stage: RTL and testbench

Instruction-fetch stage for the five-stage MIPS pipeline. It holds the fetch PC, issues requests to a variable-latency instruction memory and loads the F/D pipeline register with Instr_D/PC_D/PC4_D. It consumes the next-PC decisions made in D: the branch-target unit's pc_b, the j/jal target and the jr register. The MIPS delay slot is architectural: the instruction fetched after a redirecting D-stage instruction always retires, and the redirect takes effect on the following fetch.

---
 rtl/mips_pkg.sv | 25 ++
 rtl/fetch_stage_npc_mux.sv | 22 ++
 rtl/fetch_stage.sv | 135 +++++++++++++
 tb/tb_fetch_stage.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions: next-PC select encodings, reset PC,
// instruction-memory bounds and the fetch FSM state type.
package mips_pkg;

  localparam logic [1:0] NPC_NONE = 2'd0;
  localparam logic [1:0] NPC_BR   = 2'd1;
  localparam logic [1:0] NPC_J    = 2'd2;
  localparam logic [1:0] NPC_JR   = 2'd3;

  localparam logic [31:0] RESET_PC = 32'h0000_3000;
  localparam logic [31:0] NOP_WORD = 32'h0000_0000;
  localparam logic [31:0] IMEM_LO  = 32'h0000_3000;
  localparam logic [31:0] IMEM_HI  = 32'h0000_6FFC;

  typedef enum logic [1:0] {
    ST_START,
    ST_WAIT,
    ST_HOLD
  } fetch_state_t;

  function automatic logic fetch_addr_bad(input logic [31:0] addr);
    return (addr[1:0] != 2'b00) || (addr < IMEM_LO) || (addr > IMEM_HI);
  endfunction

endpackage

// File: rtl/fetch_stage_npc_mux.sv
// Redirect target select for the D-stage control-transfer instruction.
module npc_mux
  import mips_pkg::*;
(
  input  logic [1:0]  npc_sel_D,
  input  logic [31:0] pc_b_D,
  input  logic [25:0] instr_index,
  input  logic [3:0]  pc4_hi,
  input  logic [31:0] jr_addr_D,
  output logic [31:0] target
);

  always_comb begin
    target = pc_b_D;
    case (npc_sel_D)
      NPC_J:   target = {pc4_hi, instr_index, 2'b00};
      NPC_JR:  target = jr_addr_D;
      default: target = pc_b_D;
    endcase
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: fetch PC, variable-latency imem handshake, F/D register.
// Optional fetch address-error check enabled by defining FETCH_ADEL_EN.
module fetch_stage
  import mips_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        stall_D,
  input  logic [1:0]  npc_sel_D,
  input  logic [31:0] pc_b_D,
  input  logic [31:0] jr_addr_D,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_valid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] Instr_D,
  output logic [31:0] PC_D,
  output logic [31:0] PC4_D,
  output logic        valid_D,
  output logic        exc_adel_D
);

  fetch_state_t state, state_next;
  logic [31:0]  pc_f, npc, redirect_target, pend_target, hold_instr;
  logic         pend_valid, hold_exc, fault_f, stale;
  logic         capture, word_rdy, retire, start_bad, npc_bad;
  logic [31:0]  retire_instr;
  logic         retire_exc;

  npc_mux u_npc_mux (
    .npc_sel_D  (npc_sel_D),
    .pc_b_D     (pc_b_D),
    .instr_index(Instr_D[25:0]),
    .pc4_hi     (PC4_D[31:28]),
    .jr_addr_D  (jr_addr_D),
    .target     (redirect_target)
  );

  assign capture = valid_D && (npc_sel_D != NPC_NONE) && !stall_D;
  // A rejected address stands in for its own response so the fault retires in order.
  assign word_rdy = fault_f || (imem_valid && !stale);

  always_comb begin
    npc = pc_f + 32'd4;
    if (capture)         npc = redirect_target;
    else if (pend_valid) npc = pend_target;
  end

`ifdef FETCH_ADEL_EN
  assign start_bad = fetch_addr_bad(pc_f);
  assign npc_bad   = fetch_addr_bad(npc);
`else
  assign start_bad = 1'b0;
  assign npc_bad   = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!reset) state <= ST_START;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      ST_START: state_next = ST_WAIT;
      ST_WAIT:  if (word_rdy && stall_D) state_next = ST_HOLD;
      ST_HOLD:  if (!stall_D) state_next = ST_WAIT;
      default:  state_next = ST_START;
    endcase
  end

  always_comb begin
    retire       = 1'b0;
    imem_addr    = npc;
    retire_instr = fault_f ? NOP_WORD : imem_rdata;
    retire_exc   = fault_f;
    unique case (state)
      ST_START: imem_addr = pc_f;
      ST_WAIT:  retire = word_rdy && !stall_D;
      ST_HOLD: begin
        retire       = !stall_D;
        retire_instr = hold_instr;
        retire_exc   = hold_exc;
      end
      default: retire = 1'b0;
    endcase
    imem_req = reset && (((state == ST_START) && !start_bad) || (retire && !npc_bad));
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      pc_f        <= RESET_PC;
      pend_valid  <= 1'b0;
      pend_target <= '0;
      hold_instr  <= '0;
      hold_exc    <= 1'b0;
      fault_f     <= 1'b0;
      Instr_D     <= NOP_WORD;
      PC_D        <= '0;
      PC4_D       <= 32'd4;
      valid_D     <= 1'b0;
      exc_adel_D  <= 1'b0;
      // A request still in flight at reset has its response dropped on arrival.
      stale       <= (stale || ((state == ST_WAIT) && !fault_f)) && !imem_valid;
    end else begin
      if (imem_valid) stale <= 1'b0;
      if (state == ST_START) fault_f <= start_bad;
      if ((state == ST_WAIT) && word_rdy && stall_D) begin
        hold_instr <= retire_instr;
        hold_exc   <= retire_exc;
      end
      if (retire) begin
        pc_f       <= npc;
        fault_f    <= npc_bad;
        pend_valid <= 1'b0;
        Instr_D    <= retire_instr;
        PC_D       <= pc_f;
        PC4_D      <= pc_f + 32'd4;
        valid_D    <= 1'b1;
        exc_adel_D <= retire_exc;
      end else begin
        if (capture) begin
          pend_valid  <= 1'b1;
          pend_target <= redirect_target;
        end
        if (!stall_D) begin
          Instr_D    <= NOP_WORD;
          valid_D    <= 1'b0;
          exc_adel_D <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: memory model with fixed latency k,
// request/retire scoreboards, a redirect vector table and hand-written corner sequences.
`timescale 1ns/1ps
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        stall_D = 1'b0;
  logic [1:0]  npc_sel_D = 2'd0;
  logic [31:0] pc_b_D = '0;
  logic [31:0] jr_addr_D = '0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_valid = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic [31:0] Instr_D, PC_D, PC4_D;
  logic        valid_D, exc_adel_D;

  fetch_stage dut (
    .clk(clk), .reset(reset), .stall_D(stall_D), .npc_sel_D(npc_sel_D),
    .pc_b_D(pc_b_D), .jr_addr_D(jr_addr_D), .imem_req(imem_req),
    .imem_addr(imem_addr), .imem_valid(imem_valid), .imem_rdata(imem_rdata),
    .Instr_D(Instr_D), .PC_D(PC_D), .PC4_D(PC4_D), .valid_D(valid_D),
    .exc_adel_D(exc_adel_D)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] addr; int cyc; } req_t;
  typedef struct { logic [31:0] pc; logic [31:0] instr; logic exc; } ret_t;
  typedef struct { int due; int epoch; logic [31:0] addr; } resp_t;
  typedef struct {
    int k; logic [31:0] br_pc; logic [1:0] sel; logic [31:0] pc_b;
    logic [31:0] jr; logic [31:0] word; logic [31:0] target;
  } vec_t;

  req_t  exp_req[$];
  ret_t  exp_ret[$];
  resp_t mem_q[$];
  vec_t  vecs[6];

  int errors = 0, checks = 0, cyc = 0, epoch = 0, k = 1;
  int stall_lo = -1, stall_hi = -2;
  logic drv_rst = 1'b0, last_stall = 1'b0, last_rst = 1'b0;
  logic arm = 1'b0;
  logic [1:0]  arm_sel = 2'd0;
  logic [31:0] arm_pc = '0, arm_pc_b = '0, arm_jr = '0;
  logic [31:0] ovr_addr = 32'hFFFF_FFFF, ovr_word = '0;

  function automatic logic [31:0] word_of(input logic [31:0] a);
    if (a == ovr_addr) return ovr_word;
    return {16'h2508, a[15:0]};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h required %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push_req(input logic [31:0] a, input int c);
    req_t q;
    q.addr = a; q.cyc = c;
    exp_req.push_back(q);
  endtask

  task automatic push_ret(input logic [31:0] pc, input logic [31:0] instr, input logic exc);
    ret_t e;
    e.pc = pc; e.instr = instr; e.exc = exc;
    exp_ret.push_back(e);
  endtask

  // One cycle: check the F/D load from the last edge, then drive this cycle's inputs.
  task automatic step();
    ret_t  e;
    req_t  q;
    resp_t r;
    @(negedge clk);
    cyc++;
    if (valid_D && !last_stall && last_rst && exp_ret.size() > 0) begin
      e = exp_ret.pop_front();
      check("retire_pc", PC_D, e.pc);
      check("retire_instr", Instr_D, e.instr);
      check("retire_exc", {31'b0, exc_adel_D}, {31'b0, e.exc});
    end
    stall_D = (cyc >= stall_lo) && (cyc <= stall_hi);
    if (arm && valid_D && PC_D == arm_pc) begin
      npc_sel_D = arm_sel; pc_b_D = arm_pc_b; jr_addr_D = arm_jr;
      if (!stall_D) arm = 1'b0;
    end else begin
      npc_sel_D = 2'd0; pc_b_D = 32'h0; jr_addr_D = 32'h0;
    end
    imem_valid = 1'b0;
    imem_rdata = '0;
    if (mem_q.size() > 0 && mem_q[0].due <= cyc) begin
      r = mem_q.pop_front();
      imem_valid = 1'b1;
      imem_rdata = (r.epoch == epoch) ? word_of(r.addr) : 32'hBADB_AD00;
    end
    reset = drv_rst;
    if (!drv_rst) epoch++;
    #1;
    if (imem_req) begin
      if (exp_req.size() > 0) begin
        q = exp_req.pop_front();
        check("req_addr", imem_addr, q.addr);
        if (q.cyc >= 0) check("req_cycle", 32'(cyc), 32'(q.cyc));
      end
      r.due = cyc + k; r.epoch = epoch; r.addr = imem_addr;
      mem_q.push_back(r);
    end
    last_stall = stall_D;
    last_rst   = reset;
  endtask

  task automatic reset_dut(input int new_k, output int base);
    drv_rst = 1'b0; arm = 1'b0; stall_lo = -1; stall_hi = -2;
    ovr_addr = 32'hFFFF_FFFF;
    repeat (5) step();
    exp_req.delete(); exp_ret.delete();
    k = new_k;
    drv_rst = 1'b1;
    base = cyc + 1;
  endtask

  task automatic run_until_done(input int budget, input string name);
    int n;
    n = 0;
    while ((exp_req.size() > 0 || exp_ret.size() > 0) && n < budget) begin
      step();
      n++;
    end
    checks++;
    if (exp_req.size() > 0 || exp_ret.size() > 0) begin
      errors++;
      $display("FAIL %s_timeout: %0d requests and %0d retires outstanding, required 0",
               name, exp_req.size(), exp_ret.size());
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    vecs[0] = '{1, 32'h3000, 2'd1, 32'h3040, 32'hDEAD_BEE0, 32'h0, 32'h3040};
    vecs[1] = '{3, 32'h3010, 2'd3, 32'h1111_1110, 32'h3100, 32'h0, 32'h3100};
    vecs[2] = '{1, 32'h3008, 2'd2, 32'h2220, 32'h4440, 32'h0800_1400, 32'h5000};
    vecs[3] = '{2, 32'h3004, 2'd1, 32'h300C, 32'h5550, 32'h0, 32'h300C};
    vecs[4] = '{2, 32'h3000, 2'd2, 32'h0, 32'h0, 32'h0800_1BFF, 32'h6FFC};
    vecs[5] = '{1, 32'h300C, 2'd3, 32'h4000, 32'h3200, 32'h0, 32'h3200};

    // Reset values
    drv_rst = 1'b0;
    repeat (2) step();
    check("rst_instr", Instr_D, 32'h0);
    check("rst_pc", PC_D, 32'h0);
    check("rst_pc4", PC4_D, 32'h4);
    check("rst_valid", {31'b0, valid_D}, 32'h0);
    check("rst_exc", {31'b0, exc_adel_D}, 32'h0);
    check("rst_req", {31'b0, imem_req}, 32'h0);

    // Reset release, k=1: back-to-back requests, first instruction in D on cycle 3
    reset_dut(1, base);
    push_req(32'h3000, base); push_req(32'h3004, base + 1);
    push_req(32'h3008, base + 2); push_req(32'h300C, base + 3);
    for (int unsigned a = 32'h3000; a <= 32'h3008; a += 4) push_ret(a, word_of(a), 1'b0);
    for (int i = 0; i < 3; i++) begin
      step();
      check("first_valid", {31'b0, valid_D}, (cyc == base + 2) ? 32'h1 : 32'h0);
    end
    run_until_done(20, "release");

    // Redirect table
    foreach (vecs[i]) begin
      reset_dut(vecs[i].k, base);
      arm = 1'b1; arm_pc = vecs[i].br_pc; arm_sel = vecs[i].sel;
      arm_pc_b = vecs[i].pc_b; arm_jr = vecs[i].jr;
      if (vecs[i].sel == 2'd2) begin
        ovr_addr = vecs[i].br_pc; ovr_word = vecs[i].word;
      end
      for (int unsigned a = 32'h3000; a <= vecs[i].br_pc + 4; a += 4) begin
        push_req(a, -1);
        push_ret(a, word_of(a), 1'b0);
      end
      push_req(vecs[i].target, -1);
      push_ret(vecs[i].target, word_of(vecs[i].target), 1'b0);
      run_until_done(200, "redirect");
    end

    // Stall for 4 cycles while a response arrives
    reset_dut(1, base);
    stall_lo = base + 3; stall_hi = base + 6;
    push_req(32'h3000, base); push_req(32'h3004, base + 1);
    push_req(32'h3008, base + 2); push_req(32'h300C, base + 7);
    for (int unsigned a = 32'h3000; a <= 32'h3008; a += 4) push_ret(a, word_of(a), 1'b0);
    for (int i = 0; i < 9; i++) begin
      step();
      if (cyc >= base + 3 && cyc <= base + 6) check("stall_no_req", {31'b0, imem_req}, 32'h0);
      if (cyc >= base + 4 && cyc <= base + 7) begin
        check("stall_valid", {31'b0, valid_D}, 32'h1);
        check("stall_pc", PC_D, 32'h3004);
        check("stall_instr", Instr_D, word_of(32'h3004));
      end
    end
    run_until_done(20, "stall");

    // Reset while a response is in flight: the late response must be dropped
    reset_dut(4, base);
    push_req(32'h3000, base); push_req(32'h3000, base + 2); push_req(32'h3004, base + 6);
    push_ret(32'h3000, word_of(32'h3000), 1'b0);
    step();
    drv_rst = 1'b0;
    step();
    drv_rst = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      if (cyc == base + 5) check("stale_dropped", {31'b0, valid_D}, 32'h0);
    end
    run_until_done(20, "midreset");

`ifdef FETCH_ADEL_EN
    // jr to a misaligned address: no request, fault retires in order
    reset_dut(1, base);
    arm = 1'b1; arm_pc = 32'h3010; arm_sel = 2'd3; arm_pc_b = 32'h0; arm_jr = 32'h3002;
    for (int unsigned a = 32'h3000; a <= 32'h3014; a += 4) begin
      push_req(a, -1);
      push_ret(a, word_of(a), 1'b0);
    end
    push_ret(32'h3002, 32'h0, 1'b1);
    push_ret(32'h3006, 32'h0, 1'b1);
    run_until_done(40, "adel");
    for (int i = 0; i < 4; i++) begin
      step();
      check("adel_no_req", {31'b0, imem_req}, 32'h0);
    end
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
